// File: rtl/edge_pulse_gen.sv
// edge_pulse_gen: turns a {num, high, low} command into a registered pulse train
// with a rising-edge strobe and a completion pulse. Optional abort: EDGE_PULSE_GEN_ABORT_EN.
module edge_pulse_gen #(
  parameter int CNT_W = 8,
  parameter int NUM_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
`ifdef EDGE_PULSE_GEN_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_ready,
  input  logic [CNT_W-1:0] i_high,
  input  logic [CNT_W-1:0] i_low,
  input  logic [NUM_W-1:0] i_num,
  output logic             o_wave,
  output logic             o_rise,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_W-1:0] NUM_ONE = {{(NUM_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] high_q,  high_d;
  logic [CNT_W-1:0] low_q,   low_d;
  logic [NUM_W-1:0] num_q,   num_d;
  logic             wave_q,  wave_d;
  logic             rise_q,  rise_d;

  logic             abortReq;
  logic [CNT_W-1:0] effHigh;
  logic [CNT_W-1:0] effLow;

`ifdef EDGE_PULSE_GEN_ABORT_EN
  assign abortReq = i_abort;
`else
  assign abortReq = 1'b0;
`endif

  // Zero-length phases are stretched to one cycle so every pulse is visible.
  assign effHigh = (i_high == '0) ? CNT_ONE : i_high;
  assign effLow  = (i_low  == '0) ? CNT_ONE : i_low;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    high_d  = high_q;
    low_d   = low_q;
    num_d   = num_q;

    case (state_q)
      IDLE: begin
        if (i_valid) begin
          high_d = effHigh;
          low_d  = effLow;
          num_d  = i_num;
          if (i_num != '0) begin
            state_d = HIGH;
            phase_d = effHigh - CNT_ONE;
          end else begin
            state_d = DONE;
          end
        end
      end

      HIGH: begin
        if (abortReq) begin
          state_d = DONE;
        end else if (phase_q == '0) begin
          state_d = LOW;
          phase_d = low_q - CNT_ONE;
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end

      // The pulse count is consumed at the end of each low phase.
      LOW: begin
        if (abortReq) begin
          state_d = DONE;
        end else if (phase_q == '0) begin
          num_d = num_q - NUM_ONE;
          if (num_q == NUM_ONE) begin
            state_d = DONE;
          end else begin
            state_d = HIGH;
            phase_d = high_q - CNT_ONE;
          end
        end else begin
          phase_d = phase_q - CNT_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Waveform and strobe are registered from the next state so they line up
  // with the state they describe and stay glitch-free.
  always_comb begin
    wave_d = (state_d == HIGH);
    rise_d = (state_d == HIGH) && (state_q != HIGH);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
      num_q   <= '0;
      wave_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      high_q  <= high_d;
      low_q   <= low_d;
      num_q   <= num_d;
      wave_q  <= wave_d;
      rise_q  <= rise_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == HIGH) || (state_q == LOW);
  assign o_done  = (state_q == DONE);
  assign o_wave  = wave_q;
  assign o_rise  = rise_q;

endmodule
